// File: rtl/mux_2x1_rr_sequencer.sv
// mux_2x1_rr_sequencer: two-channel round-robin front end for mux_2x1.
// Each channel has a one-word holding register; a grant steers one held
// word through an internal mux_2x1 into a registered valid/ready output,
// tagged with the select value that produced it (1 = A, 0 = B).
// Optional build macro: MUX_2X1_RR_SEQUENCER_FIXED_PRIO_EN selects fixed
// priority (A always wins contention) and removes the round-robin pointer.
module mux_2x1_rr_sequencer #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [N-1:0] a,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [N-1:0] b,
  output logic [N-1:0] y,
  output logic         y_valid,
  input  logic         y_ready,
  output logic         s
);

  // Holding registers, one word per channel
  logic [N-1:0] r_ha;
  logic [N-1:0] r_hb;
  logic         r_ha_v;
  logic         r_hb_v;

  // Output register and its select tag
  logic [N-1:0] r_y;
  logic         r_s;
  logic         r_y_valid;

  // Handshake and arbitration wires
  logic         w_load;
  logic         w_req_a;
  logic         w_req_b;
  logic         w_gnt_a_raw;
  logic         w_gnt_a;
  logic         w_gnt_b;
  logic         w_a_accept;
  logic         w_b_accept;
  logic [N-1:0] w_mux_y;

  // The output register can take a new word when empty or being drained
  assign w_load  = ~r_y_valid | y_ready;
  assign w_req_a = r_ha_v;
  assign w_req_b = r_hb_v;

`ifdef MUX_2X1_RR_SEQUENCER_FIXED_PRIO_EN
  // Fixed priority: A wins whenever it holds a word
  assign w_gnt_a_raw = w_req_a;
`else
  // Round-robin pointer encoding: which channel was granted most recently
  localparam logic [0:0] LAST_A = 1'b1;
  localparam logic [0:0] LAST_B = 1'b0;

  logic [0:0] r_last;

  // A wins if B is idle or B was served last; reset to A so B wins first
  assign w_gnt_a_raw = w_req_a & (~w_req_b | (r_last == LAST_B));

  // Pointer follows each grant and holds when nothing is granted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= LAST_A;
    end else if (w_gnt_a) begin
      r_last <= LAST_A;
    end else if (w_gnt_b) begin
      r_last <= LAST_B;
    end
  end
`endif

  // Grants only take effect when the output register can be loaded
  assign w_gnt_a = w_load & w_gnt_a_raw;
  assign w_gnt_b = w_load & w_req_b & ~w_gnt_a_raw;

  // A holding register is free when empty or being drained this cycle;
  // readies never look at the incoming valids
  assign a_ready = ~r_ha_v | w_gnt_a;
  assign b_ready = ~r_hb_v | w_gnt_b;

  assign w_a_accept = a_valid & a_ready;
  assign w_b_accept = b_valid & b_ready;

  // Select path: s follows the A grant so y = s ? ha : hb
  mux_2x1 #(.N(N)) u_mux (
    .a (r_ha),
    .b (r_hb),
    .s (w_gnt_a_raw),
    .y (w_mux_y)
  );

  // Channel A holding register: refill wins over drain in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ha   <= '0;
      r_ha_v <= 1'b0;
    end else if (w_a_accept) begin
      r_ha   <= a;
      r_ha_v <= 1'b1;
    end else if (w_gnt_a) begin
      r_ha_v <= 1'b0;
    end
  end

  // Channel B holding register: refill wins over drain in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hb   <= '0;
      r_hb_v <= 1'b0;
    end else if (w_b_accept) begin
      r_hb   <= b;
      r_hb_v <= 1'b1;
    end else if (w_gnt_b) begin
      r_hb_v <= 1'b0;
    end
  end

  // Output register: capture the granted word, or go empty if nothing won
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y       <= '0;
      r_s       <= 1'b0;
      r_y_valid <= 1'b0;
    end else if (w_load) begin
      if (w_gnt_a | w_gnt_b) begin
        r_y       <= w_mux_y;
        r_s       <= w_gnt_a;
        r_y_valid <= 1'b1;
      end else begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign y       = r_y;
  assign s       = r_s;
  assign y_valid = r_y_valid;

endmodule

// Plain 2:1 multiplexer, y = s ? a : b
module mux_2x1 #(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         s,
  output logic [N-1:0] y
);

  assign y = s ? a : b;

endmodule

// File: tb/tb_mux_2x1_rr_sequencer.sv
// tb_mux_2x1_rr_sequencer: directed self-checking bench for the two-channel
// round-robin sequencer. Expected values are hand-derived from the intended
// behaviour; the fixed-priority build has its own expectation set.
module tb_mux_2x1_rr_sequencer;

  localparam int N = 2;

  logic         clk;
  logic         rst;
  logic         aValid;
  logic         aReady;
  logic [N-1:0] aData;
  logic         bValid;
  logic         bReady;
  logic [N-1:0] bData;
  logic [N-1:0] yData;
  logic         yValid;
  logic         yReady;
  logic         sTag;

  int assertCount = 0;
  int failCount   = 0;

  mux_2x1_rr_sequencer #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (aValid),
    .a_ready (aReady),
    .a       (aData),
    .b_valid (bValid),
    .b_ready (bReady),
    .b       (bData),
    .y       (yData),
    .y_valid (yValid),
    .y_ready (yReady),
    .s       (sTag)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expectation and count it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive all channel inputs for the next cycle
  task automatic applyStimulus(input logic av, input logic [N-1:0] ad,
                               input logic bv, input logic [N-1:0] bd,
                               input logic yr);
    aValid = av;
    aData  = ad;
    bValid = bv;
    bData  = bd;
    yReady = yr;
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef MUX_2X1_RR_SEQUENCER_FIXED_PRIO_EN
  localparam logic [N-1:0] CON_Y [4] = '{2'b01, 2'b01, 2'b01, 2'b01};
  localparam logic         CON_S [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic [N-1:0] BP_Y0 = 2'b01;
  localparam logic         BP_S0 = 1'b1;
  localparam logic         BP_AR = 1'b1;
  localparam logic         BP_BR = 1'b0;
  localparam logic [N-1:0] DR_Y1 = 2'b11;
  localparam logic         DR_S1 = 1'b1;
  localparam logic [N-1:0] DR_Y2 = 2'b10;
  localparam logic         DR_S2 = 1'b0;
  localparam logic [N-1:0] RS_Y  = 2'b01;
  localparam logic         RS_S  = 1'b1;
`else
  localparam logic [N-1:0] CON_Y [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  localparam logic         CON_S [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [N-1:0] BP_Y0 = 2'b10;
  localparam logic         BP_S0 = 1'b0;
  localparam logic         BP_AR = 1'b0;
  localparam logic         BP_BR = 1'b0;
  localparam logic [N-1:0] DR_Y1 = 2'b01;
  localparam logic         DR_S1 = 1'b1;
  localparam logic [N-1:0] DR_Y2 = 2'b11;
  localparam logic         DR_S2 = 1'b0;
  localparam logic [N-1:0] RS_Y  = 2'b10;
  localparam logic         RS_S  = 1'b0;
`endif

  // Directed scenarios: reset, single word, contention, backpressure, reset mid-stream
  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 2'b11, 1'b0, 2'b00, 1'b1);

    // Reset held two edges while A presents a word
    tick();
    tick();
    checkOutput("reset_y_valid", yValid, 1'b0);
    checkOutput("reset_y", yData, 2'b00);
    checkOutput("reset_s", sTag, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    checkOutput("reset_a_ready", aReady, 1'b1);
    checkOutput("reset_b_ready", bReady, 1'b1);
    tick();
    checkOutput("reset_no_emit_1", yValid, 1'b0);
    tick();
    checkOutput("reset_no_emit_2", yValid, 1'b0);

    // Single A word pulsed for one cycle
    applyStimulus(1'b1, 2'b10, 1'b0, 2'b00, 1'b1);
    tick();
    checkOutput("single_accept_y_valid", yValid, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    tick();
    checkOutput("single_y", yData, 2'b10);
    checkOutput("single_s", sTag, 1'b1);
    checkOutput("single_y_valid", yValid, 1'b1);
    tick();
    checkOutput("single_y_valid_drop", yValid, 1'b0);

    // Continuous contention from a freshly reset arbiter
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
    tick();
    checkOutput("contention_fill_y_valid", yValid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("contention_y_%0d", i), yData, CON_Y[i]);
      checkOutput($sformatf("contention_s_%0d", i), sTag, CON_S[i]);
      checkOutput($sformatf("contention_y_valid_%0d", i), yValid, 1'b1);
`ifdef MUX_2X1_RR_SEQUENCER_FIXED_PRIO_EN
      checkOutput($sformatf("contention_b_ready_%0d", i), bReady, 1'b0);
`endif
    end

    // Backpressure: output stalls with both channels offering words
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 2'b01, 1'b1, 2'b10, 1'b0);
    tick();
    checkOutput("bp_fill_y_valid", yValid, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b11, 1'b0);
    tick();
    checkOutput("bp_y", yData, BP_Y0);
    checkOutput("bp_s", sTag, BP_S0);
    checkOutput("bp_y_valid", yValid, 1'b1);
    checkOutput("bp_a_ready", aReady, BP_AR);
    checkOutput("bp_b_ready", bReady, BP_BR);
    applyStimulus(1'b1, 2'b11, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("bp_stall_y_%0d", i), yData, BP_Y0);
      checkOutput($sformatf("bp_stall_s_%0d", i), sTag, BP_S0);
      checkOutput($sformatf("bp_stall_y_valid_%0d", i), yValid, 1'b1);
    end
    checkOutput("bp_stall_a_ready", aReady, 1'b0);
    checkOutput("bp_stall_b_ready", bReady, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    tick();
    checkOutput("drain_y_1", yData, DR_Y1);
    checkOutput("drain_s_1", sTag, DR_S1);
    checkOutput("drain_y_valid_1", yValid, 1'b1);
    tick();
    checkOutput("drain_y_2", yData, DR_Y2);
    checkOutput("drain_s_2", sTag, DR_S2);
    checkOutput("drain_y_valid_2", yValid, 1'b1);
    tick();
    checkOutput("drain_empty", yValid, 1'b0);

    // Fill both holding registers and the output, then reset mid-stream
    applyStimulus(1'b1, 2'b01, 1'b1, 2'b10, 1'b0);
    tick();
    tick();
    checkOutput("midrst_pre_y_valid", yValid, 1'b1);
    checkOutput("midrst_pre_a_ready", aReady, 1'b0);
    checkOutput("midrst_pre_b_ready", bReady, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 2'b11, 1'b1, 2'b11, 1'b1);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
    checkOutput("midrst_y_valid", yValid, 1'b0);
    checkOutput("midrst_y", yData, 2'b00);
    checkOutput("midrst_s", sTag, 1'b0);
    checkOutput("midrst_a_ready", aReady, 1'b1);
    checkOutput("midrst_b_ready", bReady, 1'b1);
    tick();
    checkOutput("midrst_no_emit", yValid, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b1, 2'b10, 1'b1);
    tick();
    tick();
    checkOutput("midrst_first_y", yData, RS_Y);
    checkOutput("midrst_first_s", sTag, RS_S);
    checkOutput("midrst_first_y_valid", yValid, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mux_2x1_rr_sequencer.md
# mux_2x1_rr_sequencer

Two-channel round-robin sequencer that sits directly upstream of `mux_2x1`. It buffers one word per input channel and arbitrates between the two channels every cycle. It drives the `a`/`b`/`s` inputs of an internal `mux_2x1 #(N)` instance and registers the mux output behind a valid/ready handshake. The result is a single serialised stream in which each word is tagged with the select that produced it.

## Interface
Parameters:
- `N`, default 2: data width of both channels and of the output; passed to `mux_2x1`.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `a_valid`  input  1  channel A word present.
- `a_ready`  output  1  channel A word accepted this cycle when `a_valid & a_ready`.
- `a`  input  N  channel A data.
- `b_valid`  input  1  channel B word present.
- `b_ready`  output  1  channel B word accepted this cycle when `b_valid & b_ready`.
- `b`  input  N  channel B data.
- `y`  output  N  registered mux output.
- `y_valid`  output  1  `y` holds an unconsumed word.
- `y_ready`  input  1  downstream accepts `y` when `y_valid & y_ready`.
- `s`  output  1  registered select tag for the word in `y`: 1 means it came from A, 0 means from B. This matches the `mux_2x1` convention `y = s ? a : b`.

## Operation
Holding registers:
- `ha`/`hb` (N bits) with flags `ha_v`/`hb_v`.
- Channel A is captured when `a_valid & a_ready`; channel B likewise.

Load and grant:
- `load` = `~y_valid | y_ready`, i.e. the output register is free or is being drained this cycle.
- `req_a` = `ha_v`; `req_b` = `hb_v`.
- `gnt_a` = `req_a & (~req_b | last == B)`.
- `gnt_b` = `req_b & ~gnt_a`.
- Both grants are qualified by `load`.

Datapath:
- The internal `mux_2x1` is driven with `a=ha`, `b=hb`, `s=gnt_a`.
- On `load & (gnt_a | gnt_b)`, the block sets `y <= mux output`, `s <= gnt_a`, and `y_valid <= 1`.
- When the granted flag is cleared, the pointer `last` updates to the granted channel.

Drain and readiness:
- On `load` with no grant, `y_valid <= 0`. `y` and `s` hold their previous values.
- `a_ready` = `~ha_v | (gnt_a & load)`; `b_ready` likewise. A holding register may refill in the same cycle it is drained.

Arbiter state `last`:
- Encodes A or B; the reset value is A, so B wins the first contention.
- State moves to A on an A grant and to B on a B grant. Otherwise it holds.

Arithmetic: none; all paths are pure N-bit moves.

## Timing
- Reset values: `y` = 0, `s` = 0, `y_valid` = 0, `ha_v` = `hb_v` = 0, `last` = A. After reset, `a_ready` = `b_ready` = 1.
- Latency: a word accepted at edge k appears on `y` with `y_valid` = 1 after edge k+1, provided it wins and `load` is high.
- Throughput: one output word per cycle while `y_ready` = 1. Under continuous contention the output alternates A, B, A, B.
- Backpressure: while `y_valid & ~y_ready`, `y`/`s` are stable, no grant occurs, and each channel accepts at most one more word before its ready drops.
- Simultaneous events: an input accept and its holding-register drain in the same cycle are legal. The new word is stored and the old word moves to `y`.
- Mid-operation reset: `rst` high at any edge discards held and output words and restores the reset values. Inputs presented in the reset cycle are not accepted.
- Combinational paths: `a_ready`/`b_ready` depend combinationally on `y_ready`. There is no path from `a_valid`/`b_valid` to any ready.

## Configuration
- Macro `MUX_2X1_RR_SEQUENCER_FIXED_PRIO_EN`.
- Defined: fixed priority, `gnt_a` = `req_a`, so A always wins contention. `last` is not implemented.
- Undefined (default): round-robin as specified above.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with `a_valid` = 1, `a` = 2'b11 -> `y_valid` = 0, `y` = 0, `s` = 0, no word is later emitted for that input.
- Single A: `a` = 2'b10 pulsed for 1 cycle, `y_ready` = 1 -> `y` = 2'b10, `s` = 1, `y_valid` high for exactly 1 cycle, 2 edges after the accept.
- Contention: A sends 2'b01 and B sends 2'b10 every cycle, `y_ready` = 1 -> output sequence B(2'b10, `s` = 0), A, B, A…, one word per cycle. With the macro defined, the output is A only and `b_ready` stays 0 after the first B word.
- Backpressure: `y_ready` = 0 for 4 cycles with both channels valid -> `y`/`s` stable, `a_ready` = `b_ready` = 0 after one accept each. When `y_ready` is released, the 3 pending words drain with none lost or duplicated.
- Mid-stream reset: assert `rst` for 1 cycle while `ha_v` = `hb_v` = `y_valid` = 1 -> all flags are 0 the next cycle, and the first contention afterwards grants B.
